// File: rtl/reg_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard_pkg
// Description : Shared constants for the register-file scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_scoreboard_pkg;
    localparam int                 REG_CNT       = 32;
    localparam int                 REG_ADDR_W    = 5;
    localparam logic [4:0]         X0_ADDR       = 5'd0;
    localparam int                 DEFAULT_CNT_W = 2;
endpackage
`default_nettype wire

// File: rtl/reg_scoreboard_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter
// Description : Saturating up/down outstanding-write counter for one register.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_busy
);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // A simultaneous inc and dec cancel; saturate at both ends.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = (r_cnt != '0);
endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Issue-side RAW/WAW-overflow scoreboard for the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W     = DEFAULT_CNT_W,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rs1,
    input  logic [4:0]            issue_rs2,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    input  logic                  issue_we,
    input  logic [4:0]            issue_rd,
    output logic                  issue_ready,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_rd,
    input  logic                  flush,
    output logic [31:0]           busy_mask,
    output logic [CNT_W+4:0]      outstanding,
    output logic                  err_underflow
);
    localparam int               c_SUM_W   = CNT_W + REG_ADDR_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]   w_cnt [REG_CNT];
    logic [REG_CNT-1:0] w_busy;
    logic [CNT_W-1:0]   w_rs1_cnt;
    logic [CNT_W-1:0]   w_rs2_cnt;
    logic [CNT_W-1:0]   w_rd_cnt;
    logic [CNT_W-1:0]   w_rd_eff;
    logic [CNT_W-1:0]   w_wb_cnt;
    logic               w_rs1_haz;
    logic               w_rs2_haz;
    logic               w_waw;
    logic               w_accept;
    logic               w_underflow;
    logic [c_SUM_W-1:0] w_sum;
    logic               r_err_underflow;

    // x0 is hardwired to zero and never tracked.
    assign w_cnt[0]  = '0;
    assign w_busy[0] = 1'b0;

    for (genvar r = 1; r < REG_CNT; r++) begin : g_reg
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .i_inc  (w_accept && issue_we && (issue_rd == REG_ADDR_W'(r))),
            .i_dec  (wb_valid && (wb_rd == REG_ADDR_W'(r))),
            .i_clr  (flush),
            .o_cnt  (w_cnt[r]),
            .o_busy (w_busy[r])
        );
    end

    always_comb begin
        w_rs1_cnt = w_cnt[issue_rs1];
        w_rs2_cnt = w_cnt[issue_rs2];
        w_rd_cnt  = w_cnt[issue_rd];
        w_wb_cnt  = w_cnt[wb_rd];

        // With bypass, a writeback retiring the last pending write clears the source now.
        w_rs1_haz = issue_use_rs1 && (issue_rs1 != X0_ADDR) && (w_rs1_cnt != '0)
                    && !(WB_BYPASS && wb_valid && (wb_rd == issue_rs1) && (w_rs1_cnt == c_CNT_ONE));
        w_rs2_haz = issue_use_rs2 && (issue_rs2 != X0_ADDR) && (w_rs2_cnt != '0)
                    && !(WB_BYPASS && wb_valid && (wb_rd == issue_rs2) && (w_rs2_cnt == c_CNT_ONE));

        w_rd_eff  = w_rd_cnt;
        if (WB_BYPASS && wb_valid && (wb_rd == issue_rd) && (w_rd_cnt != '0)) begin
            w_rd_eff = w_rd_cnt - c_CNT_ONE;
        end
        w_waw = issue_we && (issue_rd != X0_ADDR) && (w_rd_eff == c_CNT_MAX);

        issue_ready = !flush && !w_rs1_haz && !w_rs2_haz && !w_waw;
        w_accept    = issue_valid && issue_ready;
        w_underflow = wb_valid && (wb_rd != X0_ADDR) && !flush && (w_wb_cnt == '0);
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < REG_CNT; i++) begin
            w_sum = w_sum + c_SUM_W'(w_cnt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_underflow <= 1'b0;
        end else if (w_underflow) begin
            r_err_underflow <= 1'b1;
        end
    end

    assign busy_mask     = w_busy;
    assign outstanding   = w_sum;
    assign err_underflow = r_err_underflow;
endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Directed plus random check of reg_scoreboard, both bypass modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 0, issue_use_rs1 = 0, issue_use_rs2 = 0, issue_we = 0;
    logic [4:0] issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0, wb_rd = 0;
    logic       wb_valid = 0, flush = 0;

    logic        ready0, ready1, err0, err1;
    logic [31:0] busy0, busy1;
    logic [6:0]  out0, out1;

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 0;
    int  m_cnt [2][32];
    bit  m_err [2];

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_we(issue_we), .issue_rd(issue_rd), .issue_ready(ready0), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .flush(flush), .busy_mask(busy0), .outstanding(out0), .err_underflow(err0));

    reg_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_we(issue_we), .issue_rd(issue_rd), .issue_ready(ready1), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .flush(flush), .busy_mask(busy1), .outstanding(out1), .err_underflow(err1));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pending-count rules: a source blocks while it has pending writes unless
    // (bypass) this cycle's writeback retires the last one; a destination
    // blocks when it already holds 3 pending writes after that writeback.
    function automatic bit model_ready(int b);
        int  pend1, pend2, pendd;
        bit  blocked;
        pend1 = m_cnt[b][issue_rs1];
        pend2 = m_cnt[b][issue_rs2];
        pendd = m_cnt[b][issue_rd];
        if (b == 1 && wb_valid) begin
            if (wb_rd == issue_rs1 && pend1 == 1) pend1 = 0;
            if (wb_rd == issue_rs2 && pend2 == 1) pend2 = 0;
            if (wb_rd == issue_rd && pendd > 0) pendd = pendd - 1;
        end
        blocked = (issue_use_rs1 && issue_rs1 != 0 && pend1 > 0)
               || (issue_use_rs2 && issue_rs2 != 0 && pend2 > 0)
               || (issue_we && issue_rd != 0 && pendd >= 3);
        return !flush && !blocked;
    endfunction

    function automatic int model_sum(int b);
        int s = 0;
        for (int r = 0; r < 32; r++) s += m_cnt[b][r];
        return s;
    endfunction

    function automatic logic [31:0] model_busy(int b);
        logic [31:0] m = '0;
        for (int r = 1; r < 32; r++) m[r] = (m_cnt[b][r] != 0);
        return m;
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            bit acc_wr, wb_hit;
            acc_wr = issue_valid && model_ready(b) && issue_we && issue_rd != 0;
            wb_hit = wb_valid && wb_rd != 0;
            if (rst) begin
                for (int r = 0; r < 32; r++) m_cnt[b][r] = 0;
                m_err[b] = 0;
            end else if (flush) begin
                for (int r = 0; r < 32; r++) m_cnt[b][r] = 0;
            end else begin
                if (wb_hit && m_cnt[b][wb_rd] == 0) m_err[b] = 1;
                if (!(acc_wr && wb_hit && issue_rd == wb_rd)) begin
                    if (acc_wr && m_cnt[b][issue_rd] < 3) m_cnt[b][issue_rd]++;
                    if (wb_hit && m_cnt[b][wb_rd] > 0) m_cnt[b][wb_rd]--;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready0", 64'(ready0), 64'(model_ready(0)));
            check("ready1", 64'(ready1), 64'(model_ready(1)));
            check("busy0",  64'(busy0),  64'(model_busy(0)));
            check("busy1",  64'(busy1),  64'(model_busy(1)));
            check("out0",   64'(out0),   64'(model_sum(0)));
            check("out1",   64'(out1),   64'(model_sum(1)));
            check("err0",   64'(err0),   64'(m_err[0]));
            check("err1",   64'(err1),   64'(m_err[1]));
        end
    end

    task automatic drive(input bit v, input bit u1, input int rs1, input bit u2, input int rs2,
                         input bit we, input int rd, input bit wv, input int wrd, input bit fl);
        issue_valid = v;  issue_use_rs1 = u1; issue_rs1 = 5'(rs1);
        issue_use_rs2 = u2; issue_rs2 = 5'(rs2); issue_we = we; issue_rd = 5'(rd);
        wb_valid = wv; wb_rd = 5'(wrd); flush = fl;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        step(); step();
        rst = 0;
        chk_en = 1;
        // Reset then idle
        drive(0, 1, 5, 1, 6, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_busy", 64'(busy0), 64'h0);
        check("rst_out", 64'(out0), 64'h0);
        check("rst_ready", 64'(ready0), 64'h1);
        // RAW stall
        step(); drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        step(); drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("raw_ready0", 64'(ready0), 64'h0);
        check("raw_busy", 64'(busy0), 64'h20);
        step(); drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
        @(negedge clk);
        check("raw_wb_ready0", 64'(ready0), 64'h0);
        check("raw_bypass_ready1", 64'(ready1), 64'h1);
        step(); drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("raw_after_wb", 64'(ready0), 64'h1);
        // WAW saturation on x7
        for (int i = 0; i < 3; i++) begin
            step(); drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        end
        step(); drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        @(negedge clk);
        check("waw_out", 64'(out0), 64'h3);
        check("waw_ready0", 64'(ready0), 64'h0);
        step(); drive(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        @(negedge clk);
        check("waw_wb_ready0", 64'(ready0), 64'h0);
        check("waw_wb_ready1", 64'(ready1), 64'h1);
        step(); drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        @(negedge clk);
        check("waw_after_out0", 64'(out0), 64'h2);
        check("waw_after_out1", 64'(out1), 64'h3);
        check("waw_after_ready0", 64'(ready0), 64'h1);
        // Simultaneous issue and wb to x9
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(); drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        step(); drive(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("same_busy9", 64'(busy0[9]), 64'h1);
        check("same_out", 64'(out0), 64'h1);
        // x0 handling
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(); drive(1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
            @(negedge clk);
            check("x0_ready", 64'(ready0), 64'h1);
        end
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("x0_busy", 64'(busy0), 64'h0);
        check("x0_err", 64'(err0), 64'h0);
        // Flush and underflow
        step(); drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        step(); drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        step(); drive(1, 0, 0, 0, 0, 1, 8, 0, 0, 1);
        @(negedge clk);
        check("flush_pre_busy", 64'(busy0), 64'h18);
        check("flush_ready", 64'(ready0), 64'h0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("flush_busy", 64'(busy0), 64'h0);
        check("flush_out", 64'(out0), 64'h0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        @(negedge clk);
        check("uf_err_held", 64'(err0), 64'h1);
        rst = 1;
        step(); rst = 0;
        @(negedge clk);
        check("uf_err_rst", 64'(err0), 64'h0);
        // Randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            step();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                  $urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 300) == 0);
        end
        step(); rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        @(negedge clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks register-file destinations that have been issued but not yet written back in the pipelined RISC-V core.
- Sits beside the register file at decode/issue and gates operand reads (RAW) and over-deep repeated writes (WAW overflow) until writeback lands.
- It is the producer-side bookkeeping for the register file's write port: the writeback stage clears the entries the issue stage sets.

Parameters:
- CNT_W, 2, width of each per-register outstanding-write counter; max outstanding writes per register = 2^CNT_W - 1.
- WB_BYPASS, 0, when 1, a writeback in the current cycle that retires the last pending write to a source counts as resolved for that same cycle's issue check.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- issue_valid  input  1  decode presents an instruction
- issue_rs1  input  5  source 1 address
- issue_rs2  input  5  source 2 address
- issue_use_rs1  input  1  instruction reads rs1
- issue_use_rs2  input  1  instruction reads rs2
- issue_we  input  1  instruction writes a destination register
- issue_rd  input  5  destination address
- issue_ready  output  1  no hazard; issue accepted this cycle when issue_valid && issue_ready
- wb_valid  input  1  writeback stage writes the register file this cycle
- wb_rd  input  5  writeback destination
- flush  input  1  squash all in-flight instructions (branch mispredict/trap)
- busy_mask  output  32  bit r = 1 when counter[r] != 0 (registered view)
- outstanding  output  CNT_W+5  total pending writes across all registers
- err_underflow  output  1  sticky; writeback to a register whose counter was 0

Behaviour:
- State: 31 counters (x1..x31), CNT_W bits each, plus a sticky error flag. x0 has no counter; busy_mask[0] is always 0.
- Reset (rst=1 at edge): all counters = 0, busy_mask = 0, outstanding = 0, err_underflow = 0. rst overrides flush, issue and wb.
- A source is hazarded when its use bit is 1, its address != 0, and counter[addr] != 0.
- With WB_BYPASS=1, a hazarded source is treated as clear when wb_valid && wb_rd == addr && counter[addr] == 1.
- A WAW overflow exists when issue_we && issue_rd != 0 && counter[issue_rd] is saturated (all ones), after applying the same-cycle wb decrement when WB_BYPASS=1.
- issue_ready is combinational: 1 when there is no rs1 hazard, no rs2 hazard and no WAW overflow. It ignores issue_valid. It is forced to 0 during a flush cycle.
- Accepted issue with issue_we && issue_rd != 0: counter[issue_rd] += 1 at the next edge.
- wb_valid && wb_rd != 0: counter[wb_rd] -= 1 at the next edge.
  - If the counter is 0, it stays 0 and err_underflow sets. Only rst clears err_underflow.
- Issue and wb to the same register in the same cycle: the counter is unchanged.
- Writes to x0 (issue or wb) have no effect and never set the error.
- flush=1: all counters clear at the next edge. Any issue or wb in that cycle is discarded; wb does not set the error. err_underflow is held.
- busy_mask and outstanding are derived from the registered counters, so changes appear one cycle after the causing edge. outstanding is the sum of the counters.
- Latency: issue → busy visible next cycle; wb → clear visible next cycle, or same-cycle ready when WB_BYPASS=1.
- No other outputs depend combinationally on issue_valid.

Decomposition:
- Shared package: REG_CNT = 32, REG_ADDR_W = 5, the x0 address constant, and the default CNT_W.
- One natural sub-module, sb_counter: a single saturating up/down counter with inc, dec, clr and a busy output. Instantiate it 31 times in a generate loop. Keep the hazard compare and the popcount sum in the top module.

Test Plan:
- Reset then idle: rst high for 2 cycles → busy_mask = 0, outstanding = 0, issue_ready = 1 for rs1 = 5, rs2 = 6.
- RAW stall: issue we rd = 5 accepted; next cycle issue rs1 = 5 → issue_ready = 0, busy_mask = 0x20. wb_rd = 5 → one cycle later issue_ready = 1. With WB_BYPASS=1, ready = 1 in the wb cycle itself.
- WAW saturation (CNT_W=2): three accepted writes to x7 → outstanding = 3. A fourth write to x7 → issue_ready = 0. Add wb x7 with WB_BYPASS=0 → ready next cycle, counter = 2.
- Simultaneous issue rd = 9 and wb rd = 9 with counter[9] = 1 → counter stays 1; busy_mask[9] stays 1.
- x0 handling: issue rd = 0 and wb rd = 0 repeatedly → busy_mask = 0, err_underflow = 0; reading rs1 = 0 is always ready.
- Flush and underflow: set x3 and x4 busy, assert flush with a concurrent issue rd = 8 → next cycle busy_mask = 0, outstanding = 0. A later wb rd = 3 → err_underflow = 1, held until rst.
